// File: rtl/vicii_pkg.sv
// Shared types and constants for the VIC-II memory responder.
package vicii_pkg;

  // Bus-steal sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_STEAL = 2'd2
  } steal_state_e;

  // Data source for a VIC fetch
  typedef enum logic {
    SRC_RAM  = 1'b0,
    SRC_CROM = 1'b1
  } src_sel_e;

  // Requester that owns an in-flight memory access
  typedef enum logic {
    OWN_VIC = 1'b0,
    OWN_CPU = 1'b1
  } slot_owner_e;

  // vic_ao[13:12] value that selects the character ROM in even banks
  localparam logic [1:0] CHROM_WINDOW = 2'b01;

  // Default number of CPU cycles from BA to AEC
  localparam int STALL_CYCLES_DEF = 3;

endpackage

// File: rtl/vicii_addr_map.sv
// Maps {vic_bank, vic_ao} onto the RAM address, the character ROM address
// and the data source of a VIC fetch.
// Build option: VICII_CHAR_ROM_EN enables the character ROM window; without
// it every fetch goes to RAM and crom_a stays at zero.
module vicii_addr_map
  import vicii_pkg::*;
(
  input  logic [1:0]  vic_bank,
  input  logic [13:0] vic_ao,
  output logic [15:0] ram_a,
  output logic [11:0] crom_a,
  output src_sel_e    src
);

  // Decode the fetch address into RAM/ROM addresses and the source select
  always_comb begin
    ram_a  = {vic_bank, vic_ao};
    crom_a = 12'h000;
    src    = SRC_RAM;
`ifdef VICII_CHAR_ROM_EN
    if ((vic_bank[0] == 1'b0) && (vic_ao[13:12] == CHROM_WINDOW)) begin
      crom_a = vic_ao[11:0];
      src    = SRC_CROM;
    end else begin
      crom_a = 12'h000;
      src    = SRC_RAM;
    end
`else
    crom_a = 12'h000;
    src    = SRC_RAM;
`endif
  end

endmodule

// File: rtl/vicii_mem_responder.sv
// Memory-side responder for the VIC-II: alternates the memory port between
// VIC and CPU half-cycles, routes returning data by the slot-owner flag and
// runs the BA -> AEC bus-steal sequence.
// Build option: VICII_CHAR_ROM_EN (character ROM window, see vicii_addr_map).
module vicii_mem_responder
  import vicii_pkg::*;
#(
  parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] vic_ao,
  input  logic        vic_ba,
  input  logic [1:0]  vic_bank,
  output logic [7:0]  vic_di,
  output logic        vic_aec,
  output logic        phase,
  input  logic [15:0] cpu_a,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  output logic [15:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_do,
  input  logic [7:0]  ram_di,
  output logic [11:0] crom_a,
  input  logic [7:0]  crom_di
);

  localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);

  steal_state_e     state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             rdy_nxt, aec_nxt;

  logic [15:0]      map_ram_a;
  logic [11:0]      map_crom_a;
  src_sel_e         map_src;

  slot_owner_e      owner_r;
  src_sel_e         src_r;
  logic             inflight_r;
  logic             vic_slot;

  vicii_addr_map u_addr_map (
    .vic_bank (vic_bank),
    .vic_ao   (vic_ao),
    .ram_a    (map_ram_a),
    .crom_a   (map_crom_a),
    .src      (map_src)
  );

  // The coming edge issues a VIC access on phase 1->0, or on any edge while stealing
  assign vic_slot = phase | (state_r == ST_STEAL);

  // Next-state logic; BA is only looked at on CPU-cycle boundaries (phase 1->0)
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    rdy_nxt   = cpu_rdy;
    aec_nxt   = vic_aec;
    if (phase) begin
      case (state_r)
        ST_IDLE: begin
          if (vic_ba) begin
            state_nxt = ST_STALL;
            cnt_nxt   = '0;
            rdy_nxt   = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_STALL: begin
          if (!vic_ba) begin
            state_nxt = ST_IDLE;
            rdy_nxt   = 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            state_nxt = ST_STEAL;
            aec_nxt   = 1'b1;
          end else begin
            cnt_nxt   = cnt_r + CNT_W'(1);
          end
        end
        ST_STEAL: begin
          if (!vic_ba) begin
            state_nxt = ST_IDLE;
            aec_nxt   = 1'b0;
            rdy_nxt   = 1'b1;
          end else begin
            state_nxt = ST_STEAL;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          rdy_nxt   = 1'b1;
          aec_nxt   = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Phase toggle, steal-sequencer state and its registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 1'b1;
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      cpu_rdy <= 1'b1;
      vic_aec <= 1'b0;
    end else begin
      phase   <= ~phase;
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      cpu_rdy <= rdy_nxt;
      vic_aec <= aec_nxt;
    end
  end

  // Memory port: return data of the previous slot, then issue this slot's access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_a      <= 16'h0000;
      ram_we     <= 1'b0;
      ram_do     <= 8'h00;
      crom_a     <= 12'h000;
      vic_di     <= 8'h00;
      cpu_di     <= 8'h00;
      owner_r    <= OWN_VIC;
      src_r      <= SRC_RAM;
      inflight_r <= 1'b0;
    end else begin
      if (inflight_r) begin
        if (owner_r == OWN_VIC) begin
          vic_di <= (src_r == SRC_CROM) ? crom_di : ram_di;
        end else begin
          cpu_di <= ram_di;
        end
      end
      if (vic_slot) begin
        ram_a   <= map_ram_a;
        crom_a  <= map_crom_a;
        ram_we  <= 1'b0;
        owner_r <= OWN_VIC;
        src_r   <= map_src;
      end else begin
        ram_a   <= cpu_a;
        ram_we  <= cpu_we;
        ram_do  <= cpu_do;
        owner_r <= OWN_CPU;
        src_r   <= SRC_RAM;
      end
      inflight_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vicii_mem_responder.sv
// Scoreboard bench for vicii_mem_responder: expectations are queued with the
// edge number after which they must hold and compared at the next falling edge.
module tb_vicii_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] vic_ao;
  logic        vic_ba;
  logic [1:0]  vic_bank;
  logic [7:0]  vic_di;
  logic        vic_aec;
  logic        phase;
  logic [15:0] cpu_a;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic [15:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_do;
  logic [7:0]  ram_di;
  logic [11:0] crom_a;
  logic [7:0]  crom_di;

  localparam int K_VDI = 0, K_CDI = 1, K_RA = 2, K_CA = 3, K_WE = 4,
                 K_DO = 5, K_PH = 6, K_RDY = 7, K_AEC = 8;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [7:0]  mem    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [7:0]  crom   [0:4095];
  logic [7:0]  last_cpu;
  bit          last_valid;

  always #5 clk = ~clk;

  assign ram_di  = mem[ram_a];
  assign crom_di = crom[crom_a];

  vicii_mem_responder #(.STALL_CYCLES(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .vic_ao   (vic_ao),
    .vic_ba   (vic_ba),
    .vic_bank (vic_bank),
    .vic_di   (vic_di),
    .vic_aec  (vic_aec),
    .phase    (phase),
    .cpu_a    (cpu_a),
    .cpu_we   (cpu_we),
    .cpu_do   (cpu_do),
    .cpu_di   (cpu_di),
    .cpu_rdy  (cpu_rdy),
    .ram_a    (ram_a),
    .ram_we   (ram_we),
    .ram_do   (ram_do),
    .ram_di   (ram_di),
    .crom_a   (crom_a),
    .crom_di  (crom_di)
  );

  function automatic logic [7:0] init_pat(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int due, input logic [15:0] exp);
    sb_item_t it;
    it.due  = due;
    it.kind = kind;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_VDI:   return {8'h00, vic_di};
      K_CDI:   return {8'h00, cpu_di};
      K_RA:    return ram_a;
      K_CA:    return {4'h0, crom_a};
      K_WE:    return {15'h0000, ram_we};
      K_DO:    return {8'h00, ram_do};
      K_PH:    return {15'h0000, phase};
      K_RDY:   return {15'h0000, cpu_rdy};
      K_AEC:   return {15'h0000, vic_aec};
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      K_VDI:   return "vic_di";
      K_CDI:   return "cpu_di";
      K_RA:    return "ram_a";
      K_CA:    return "crom_a";
      K_WE:    return "ram_we";
      K_DO:    return "ram_do";
      K_PH:    return "phase";
      K_RDY:   return "cpu_rdy";
      K_AEC:   return "vic_aec";
      default: return "unknown";
    endcase
  endfunction

  task automatic drain();
    for (int j = sb_q.size() - 1; j >= 0; j--) begin
      if (sb_q[j].due == cyc) begin
        check_val($sformatf("%s@%0d", kind_name(sb_q[j].kind), cyc),
                  {16'h0000, observe(sb_q[j].kind)}, {16'h0000, sb_q[j].exp});
        sb_q.delete(j);
      end
    end
  endtask

  // One clock: RAM model write on the rising edge, compare on the falling edge
  task automatic step();
    logic        wr_en;
    logic [15:0] wr_a;
    logic [7:0]  wr_d;
    wr_en = ram_we;
    wr_a  = ram_a;
    wr_d  = ram_do;
    @(posedge clk);
    if (wr_en) mem[wr_a] <= wr_d;
    cyc++;
    @(negedge clk);
    drain();
  endtask

  task automatic tb_map(input logic [1:0] b, input logic [13:0] ao,
                        output bit is_crom, output logic [15:0] ra, output logic [11:0] ca);
    ra      = {b, ao};
    ca      = 12'h000;
    is_crom = 1'b0;
`ifdef VICII_CHAR_ROM_EN
    if ((b[0] == 1'b0) && (ao[13:12] == 2'b01)) begin
      is_crom = 1'b1;
      ca      = ao[11:0];
    end
`endif
  endtask

  // Drive one clock's inputs, queue what the next edges must show, then clock
  task automatic drive_cycle(input logic [1:0] b, input logic [13:0] ao, input logic ba,
                             input logic [15:0] ca, input logic we, input logic [7:0] dout,
                             input bit stolen);
    int          e;
    bit          is_crom;
    logic [15:0] ra;
    logic [11:0] cra;
    vic_bank = b;
    vic_ao   = ao;
    vic_ba   = ba;
    cpu_a    = ca;
    cpu_we   = we;
    cpu_do   = dout;
    e = cyc + 1;
    push(K_PH, e, (e % 2 == 0) ? 16'd1 : 16'd0);
    if ((e % 2 == 1) || stolen) begin
      tb_map(b, ao, is_crom, ra, cra);
      if (is_crom) begin
        push(K_CA, e, {4'h0, cra});
        push(K_VDI, e + 1, {8'h00, crom[cra]});
      end else begin
        push(K_RA, e, ra);
        push(K_VDI, e + 1, {8'h00, shadow[ra]});
      end
      push(K_WE, e, 16'd0);
      if (stolen && last_valid) push(K_CDI, e + 1, {8'h00, last_cpu});
    end else begin
      push(K_RA, e, ca);
      push(K_WE, e, {15'h0000, we});
      if (we) begin
        push(K_DO, e, {8'h00, dout});
        shadow[ca] = dout;
        last_valid = 1'b0;
      end else begin
        push(K_CDI, e + 1, {8'h00, shadow[ca]});
        last_cpu   = shadow[ca];
        last_valid = 1'b1;
      end
    end
    step();
  endtask

  logic [1:0]  tbl_bank [0:4];
  logic [13:0] tbl_ao   [0:4];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = init_pat(16'(i));
      shadow[i] = init_pat(16'(i));
    end
    for (int i = 0; i < 4096; i++) crom[i] = ~i[7:0];
    crom[12'h008]  = 8'hA5;
    mem[16'hC401]    = 8'h5A;
    shadow[16'hC401] = 8'h5A;
    tbl_bank[0] = 2'b00; tbl_ao[0] = 14'h1008;
    tbl_bank[1] = 2'b10; tbl_ao[1] = 14'h1FFF;
    tbl_bank[2] = 2'b01; tbl_ao[2] = 14'h1008;
    tbl_bank[3] = 2'b00; tbl_ao[3] = 14'h0FFF;
    tbl_bank[4] = 2'b00; tbl_ao[4] = 14'h2000;

    reset_n = 1'b0; vic_ao = 14'h0000; vic_ba = 1'b0; vic_bank = 2'b00;
    cpu_a = 16'h0000; cpu_we = 1'b0; cpu_do = 8'h00;
    last_cpu = 8'h00; last_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_phase",   {31'd0, phase},   32'd1);
    check_val("rst_ram_a",   {16'd0, ram_a},   32'd0);
    check_val("rst_ram_we",  {31'd0, ram_we},  32'd0);
    check_val("rst_ram_do",  {24'd0, ram_do},  32'd0);
    check_val("rst_crom_a",  {20'd0, crom_a},  32'd0);
    check_val("rst_vic_di",  {24'd0, vic_di},  32'd0);
    check_val("rst_cpu_di",  {24'd0, cpu_di},  32'd0);
    check_val("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_val("rst_vic_aec", {31'd0, vic_aec}, 32'd0);
    reset_n = 1'b1;
    cyc = 0;

    // Bank 3 fetch from RAM plus a CPU read
    drive_cycle(2'b11, 14'h0401, 1'b0, 16'h2345, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b11, 14'h0401, 1'b0, 16'h2345, 1'b0, 8'h00, 1'b0);

    // Address map patterns, CPU slots alternate write / read-back
    for (int k = 0; k < 5; k++) begin
      drive_cycle(tbl_bank[k], tbl_ao[k], 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
      if (k % 2 == 0)
        drive_cycle(tbl_bank[k], tbl_ao[k], 1'b0, 16'h0800 + 16'(k), 1'b1, 8'h10 + 8'(k), 1'b0);
      else
        drive_cycle(tbl_bank[k], tbl_ao[k], 1'b0, 16'h0800 + 16'(k - 1), 1'b0, 8'h00, 1'b0);
    end

    // BA pulse confined to a non-boundary edge is never seen
    drive_cycle(2'b01, 14'h0100, 1'b0, 16'h1000, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b01, 14'h0101, 1'b1, 16'h1001, 1'b0, 8'h00, 1'b0);
    push(K_RDY, cyc + 1, 16'd1);
    push(K_AEC, cyc + 1, 16'd0);
    drive_cycle(2'b01, 14'h0102, 1'b0, 16'h1002, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b01, 14'h0103, 1'b0, 16'h1003, 1'b0, 8'h00, 1'b0);

    // BA high for one CPU cycle: STALL then straight back to IDLE
    push(K_RDY, cyc + 1, 16'd0);
    push(K_AEC, cyc + 1, 16'd0);
    drive_cycle(2'b01, 14'h0104, 1'b1, 16'h1004, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b01, 14'h0105, 1'b1, 16'h1005, 1'b0, 8'h00, 1'b0);
    push(K_RDY, cyc + 1, 16'd1);
    push(K_AEC, cyc + 1, 16'd0);
    drive_cycle(2'b01, 14'h0106, 1'b0, 16'h1006, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b01, 14'h0107, 1'b0, 16'h1007, 1'b0, 8'h00, 1'b0);

    // Full stall -> steal -> release, with CPU writes in STALL and in STEAL
    for (int i = 0; i < 16; i++) begin
      int          er;
      logic [15:0] ca;
      logic        we;
      logic [7:0]  dd;
      er = i + 1;
      ca = 16'h0400 + 16'(i); we = 1'b0; dd = 8'h00;
      if (i == 1) begin ca = 16'h0300; we = 1'b1; dd = 8'h77; end
      if (i == 7 || i == 9) begin ca = 16'h0301; we = 1'b1; dd = 8'h99; end
      if (i == 11) ca = 16'h0301;
      if (i == 13) ca = 16'h0300;
      if (er % 2 == 1) begin
        push(K_RDY, cyc + 1, (er <= 9) ? 16'd0 : 16'd1);
        push(K_AEC, cyc + 1, (er >= 7 && er <= 9) ? 16'd1 : 16'd0);
      end
      drive_cycle(2'b01, 14'h2000 + 14'(i), (i < 10), ca, we, dd, (er == 8 || er == 10));
    end

    // Reach STEAL again, then reset asynchronously in the middle of it
    for (int i = 0; i < 8; i++) begin
      if (i == 6) push(K_AEC, cyc + 1, 16'd1);
      drive_cycle(2'b01, 14'h3000 + 14'(i), 1'b1, 16'h0500 + 16'(i), 1'b0, 8'h00, (i == 7));
    end
    step();
    step();
    check_val("sb_empty_pre_rst", sb_q.size(), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_vic_aec", {31'd0, vic_aec}, 32'd0);
    check_val("arst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
    check_val("arst_phase",   {31'd0, phase},   32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    vic_ba = 1'b0;
    cyc = 0;
    last_valid = 1'b0;
    drive_cycle(2'b00, 14'h0123, 1'b0, 16'h0600, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b00, 14'h0124, 1'b0, 16'h0601, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b10, 14'h0125, 1'b0, 16'h0602, 1'b0, 8'h00, 1'b0);
    drive_cycle(2'b10, 14'h0126, 1'b0, 16'h0603, 1'b0, 8'h00, 1'b0);
    step();
    step();
    check_val("sb_empty_end", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vicii_mem_responder.md
# vicii_mem_responder

Memory-side responder for the VIC-II fetch interface. It answers the address/BA requests issued by the VIC-II fetch units (sprite, character, bitmap), and maps each 14-bit VIC address through the 2-bit bank select into system RAM or the character ROM. It time-multiplexes the memory port between the VIC half-cycle and the CPU half-cycle, and applies the BA-to-AEC stall sequence to the CPU. It sits between the VIC-II top level, the 6502 core and the RAM/ROM blocks.

## Interface
Parameters:
- STALL_CYCLES, 3, CPU cycles between BA assertion and VIC taking the CPU half-cycle (AEC)

Ports:
- clk  in  1  system clock; one memory access per clk
- reset_n  in  1  one clock; reset is asynchronous and active-low
- vic_ao  in  14  VIC fetch address
- vic_ba  in  1  OR of all VIC bus requests, active-high
- vic_bank  in  2  VIC bank select, already inverted from CIA2 port A
- vic_di  out  8  fetched data to VIC
- vic_aec  out  1  1 = VIC owns both half-cycles
- phase  out  1  0 = VIC half-cycle, 1 = CPU half-cycle
- cpu_a  in  16  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_do  in  8  CPU write data
- cpu_di  out  8  read data to CPU
- cpu_rdy  out  1  CPU ready; 0 stalls CPU reads
- ram_a  out  16  RAM address
- ram_we  out  1  RAM write enable
- ram_do  out  8  RAM write data
- ram_di  in  8  RAM read data, valid one clk after ram_a
- crom_a  out  12  character ROM address
- crom_di  in  8  character ROM data, valid one clk after crom_a

## Operation
- Address map: full VIC address = {vic_bank, vic_ao}. Char ROM window: vic_bank[0]==0 and vic_ao[13:12]==2'b01 -> crom_a = vic_ao[11:0]; data source = crom_di. Otherwise ram_a = {vic_bank, vic_ao}; source = ram_di.
- An internal slot-owner/source flag records which requester and which source own the in-flight access. Returning data is routed using this flag.
- CPU accesses go straight to RAM: ram_a = cpu_a, no banking/IO decode in this block.
- Bus-steal FSM, evaluated only at CPU-cycle boundaries (edges where phase goes 1->0):
  - IDLE: vic_ba=1 -> STALL with cnt=0 and cpu_rdy<=0.
  - STALL: vic_ba=0 -> IDLE with cpu_rdy<=1. cnt==STALL_CYCLES-1 -> STEAL with vic_aec<=1. Otherwise cnt+1.
  - STEAL: vic_ba=0 -> IDLE with vic_aec<=0 and cpu_rdy<=1.
- CPU writes complete during STALL (6502 ignores RDY on writes): ram_we = cpu_we in CPU slots outside STEAL. In STEAL, ram_we = 0.
- Reset mid-operation (async): FSM -> IDLE. Reset values: phase=1, ram_a=0, ram_we=0, ram_do=0, crom_a=0, vic_di=0, cpu_di=0, cpu_rdy=1, vic_aec=0. An in-flight access is discarded.

## Timing
- phase toggles every clk. The first edge after reset release drives phase=0.
- Edge setting phase=0: ram_a/crom_a <= mapped vic_ao, ram_we<=0. Also cpu_di <= ram_di from the previous CPU slot (not updated if that slot was stolen).
- Edge setting phase=1:
  - vic_di <= selected source.
  - Not STEAL: ram_a <= cpu_a, ram_we <= cpu_we, ram_do <= cpu_do.
  - STEAL: ram_a/crom_a <= mapped vic_ao, and vic_di also updates on the next edge.
- VIC read latency: vic_ao stable before edge k, vic_di valid after edge k+1 (2 clk). This matches fetch units that place the address and sample data two clk later.
- vic_ba sampled only at CPU-cycle boundaries. A pulse that falls between boundaries is not seen.
- Steal begins on the STALL_CYCLES-th boundary after the request is seen. Release takes effect on the first boundary with vic_ba=0.

## Configuration
- VICII_CHAR_ROM_EN defined: char ROM window mapping active as above.
- Not defined: all VIC fetches go to RAM, crom_a held at 0, crom_di ignored.

## Structure
- Package vicii_pkg holds:
  - FSM state enum (IDLE/STALL/STEAL)
  - CHROM_WINDOW = 2'b01
  - default STALL_CYCLES
  - source-select enum (RAM/CROM)
- One sub-module, vicii_addr_map: combinational {vic_bank, vic_ao} -> ram_a/crom_a/source select, with the VICII_CHAR_ROM_EN guard inside.

## Test plan
- Bank 3, vic_ao=14'h0401, RAM[16'hC401]=8'h5A -> ram_a=16'hC401 after edge k, vic_di=8'h5A after edge k+1.
- Bank 0, vic_ao=14'h1008, crom_di=8'hA5 -> crom_a=12'h008, vic_di=8'hA5. Same stimulus without VICII_CHAR_ROM_EN -> ram_a=16'h1008.
- vic_ba 0->1 at a boundary -> cpu_rdy=0 immediately, vic_aec=1 exactly 3 boundaries later. A CPU write issued during STALL reaches RAM; no ram_we during STEAL.
- vic_ba high for one CPU cycle only -> STALL then IDLE, vic_aec never asserted, cpu_rdy back to 1 at next boundary.
- reset_n low mid-STEAL -> vic_aec=0, cpu_rdy=1, phase=1 asynchronously; first access after release is a VIC slot.
